// File: rtl/snake_pkg.sv
// Shared constants, state encoding and direction helpers for the snake step controller.
package snake_pkg;

    localparam int LEN_W = 10;
    localparam logic [LEN_W-1:0] INIT_LEN = 10'd3;
    localparam logic [LEN_W-1:0] MAX_LEN  = 10'd200;

    localparam logic [3:0] DIR_RIGHT = 4'b1000;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0001;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        STEP = 3'd2,
        BODY = 3'd3,
        OVER = 3'd4
    } state_t;

    // 180-degree reversal of a one-hot direction; unknown codes map to none.
    function automatic logic [3:0] dir_opposite(input logic [3:0] dir);
        case (dir)
            DIR_RIGHT: dir_opposite = DIR_LEFT;
            DIR_LEFT:  dir_opposite = DIR_RIGHT;
            DIR_UP:    dir_opposite = DIR_DOWN;
            DIR_DOWN:  dir_opposite = DIR_UP;
            default:   dir_opposite = 4'b0000;
        endcase
    endfunction

    // Reduce simultaneous button edges {right,left,up,down} to one candidate.
    function automatic logic [3:0] dir_pick(input logic [3:0] edges);
        if (edges[3]) begin
            dir_pick = DIR_RIGHT;
        end else if (edges[2]) begin
            dir_pick = DIR_LEFT;
        end else if (edges[1]) begin
            dir_pick = DIR_UP;
        end else if (edges[0]) begin
            dir_pick = DIR_DOWN;
        end else begin
            dir_pick = 4'b0000;
        end
    endfunction

endpackage

// File: rtl/snake_step_ctrl_if.sv
// Signals exchanged between the step controller and the snake movement stage.
interface snake_step_ctrl_if;
    import snake_pkg::*;

    logic [3:0]       way;
    logic             vld;
    logic [LEN_W-1:0] length;
    logic             move_rst;
    logic             eat;
    logic             is_end;
    logic             bite_self;

    modport master (
        output way, vld, length, move_rst,
        input  eat, is_end, bite_self
    );

    modport slave (
        input  way, vld, length, move_rst,
        output eat, is_end, bite_self
    );
endinterface

// File: rtl/snake_step_ctrl_debounce.sv
// One-bit button conditioner: 2-FF synchronizer, stability counter and
// a registered one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             rise_r;
    logic [CNT_W-1:0] cnt_r;
    logic             diff_s;
    logic             accept_s;

    assign diff_s   = sync2_r ^ level_r;
    assign accept_s = diff_s && (cnt_r == CNT_LAST);
    assign rise     = rise_r;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            rise_r <= accept_s & sync2_r;
            if (!diff_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (accept_s) begin
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/snake_step_ctrl.sv
// Paces snake head steps, filters direction input, tracks length and game-over.
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV     = 25000000,
    parameter int DEB_CYCLES   = 500000,
    parameter int BODY_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        btn,
    input  logic              start,
    snake_step_ctrl_if.master mv,
    output logic              game_over,
    output logic              running
);
    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int BODY_W = $clog2(BODY_TIMEOUT + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [BODY_W-1:0] BODY_LAST = BODY_W'(BODY_TIMEOUT - 1);

    state_t           state_r, state_nxt_s;
    logic [TICK_W-1:0] tick_r, tick_nxt_s;
    logic [BODY_W-1:0] body_r, body_nxt_s;
    logic [3:0]       way_r, pend_r;
    logic [LEN_W-1:0] len_r;
    logic             grow_r;
    logic             vld_r, move_rst_r, game_over_r, running_r;
    logic [3:0]       btn_rise_s;
    logic             start_rise_s;
    logic [3:0]       cand_s;
    logic             dir_ok_s;
    logic             restart_s;
    logic             step_entry_s;
    logic             run_s;

    function automatic logic is_run(input state_t s);
        is_run = (s == WAIT) || (s == STEP) || (s == BODY);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk   (clk),
                .rst_n (rst),
                .din   (btn[gi]),
                .rise  (btn_rise_s[gi])
            );
        end
    endgenerate

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start_deb (
        .clk   (clk),
        .rst_n (rst),
        .din   (start),
        .rise  (start_rise_s)
    );

    // Reversals are judged against the committed heading, not the pending one.
    assign cand_s       = dir_pick(btn_rise_s);
    assign dir_ok_s     = (cand_s != 4'b0000) && (cand_s != dir_opposite(way_r));
    assign run_s        = is_run(state_r);
    assign step_entry_s = (state_r == WAIT) && (state_nxt_s == STEP);

    // Next-state and counter update; bite_self outranks tick expiry and is_end.
    always_comb begin
        state_nxt_s = state_r;
        tick_nxt_s  = tick_r;
        body_nxt_s  = body_r;
        restart_s   = 1'b0;
        case (state_r)
            IDLE, OVER: begin
                if (start_rise_s) begin
                    state_nxt_s = WAIT;
                    tick_nxt_s  = {TICK_W{1'b0}};
                    restart_s   = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            WAIT: begin
                if (mv.bite_self) begin
                    state_nxt_s = OVER;
                    tick_nxt_s  = {TICK_W{1'b0}};
                end else if (tick_r == TICK_LAST) begin
                    state_nxt_s = STEP;
                    tick_nxt_s  = {TICK_W{1'b0}};
                end else begin
                    tick_nxt_s = tick_r + TICK_W'(1);
                end
            end
            STEP: begin
                state_nxt_s = BODY;
                body_nxt_s  = {BODY_W{1'b0}};
            end
            BODY: begin
                if (mv.bite_self) begin
                    state_nxt_s = OVER;
                end else if (mv.is_end || (body_r == BODY_LAST)) begin
                    state_nxt_s = WAIT;
                    tick_nxt_s  = {TICK_W{1'b0}};
                end else begin
                    body_nxt_s = body_r + BODY_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counters and registered status strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            tick_r      <= {TICK_W{1'b0}};
            body_r      <= {BODY_W{1'b0}};
            vld_r       <= 1'b0;
            move_rst_r  <= 1'b0;
            game_over_r <= 1'b0;
            running_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            tick_r      <= tick_nxt_s;
            body_r      <= body_nxt_s;
            vld_r       <= (state_nxt_s == STEP);
            move_rst_r  <= restart_s;
            game_over_r <= (state_nxt_s == OVER);
            running_r   <= is_run(state_nxt_s);
        end
    end

    // Heading, pending heading, length and growth request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            way_r  <= DIR_RIGHT;
            pend_r <= DIR_RIGHT;
            len_r  <= INIT_LEN;
            grow_r <= 1'b0;
        end else if (restart_s) begin
            way_r  <= DIR_RIGHT;
            pend_r <= DIR_RIGHT;
            len_r  <= INIT_LEN;
            grow_r <= 1'b0;
        end else begin
            if (step_entry_s) begin
                way_r <= pend_r;
                if (grow_r) begin
                    len_r <= (len_r >= MAX_LEN) ? MAX_LEN : (len_r + 10'd1);
                end
            end
            if (run_s && dir_ok_s) begin
                pend_r <= cand_s;
            end
            // A new eat wins over consumption so it is carried to the next step.
            if (run_s && mv.eat) begin
                grow_r <= 1'b1;
            end else if (step_entry_s) begin
                grow_r <= 1'b0;
            end
        end
    end

    assign mv.way      = way_r;
    assign mv.vld      = vld_r;
    assign mv.length   = len_r;
    assign mv.move_rst = move_rst_r;
    assign game_over   = game_over_r;
    assign running     = running_r;
endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed and randomized bench for snake_step_ctrl with a behavioural game model.
`timescale 1ns/1ps
module tb_snake_step_ctrl;
    localparam int TICK_DIV = 8;
    localparam int DEB      = 4;
    localparam int BODY_TO  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       start;
    logic       game_over;
    logic       running;

    snake_step_ctrl_if u_if();

    snake_step_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB), .BODY_TIMEOUT(BODY_TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .start     (start),
        .mv        (u_if),
        .game_over (game_over),
        .running   (running)
    );

    always #5 clk = ~clk;

    int cyc, vld_cnt, mr_cnt, both_cnt, last_mr_cyc;
    int passed, total;
    int exp_vld_cnt;
    int t_vld;
    int body_c, last_d;
    // model: direction indices 0=right 1=left 2=up 3=down; opposite is index^1
    int m_way, m_pend, m_len;
    bit m_grow;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.vld === 1'b1) vld_cnt++;
        if (u_if.move_rst === 1'b1) begin
            mr_cnt++;
            last_mr_cyc = cyc;
        end
        if (u_if.vld === 1'b1 && u_if.move_rst === 1'b1) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] base;
        base = 4'b1000;
        return base >> i;
    endfunction

    function automatic int pick_idx(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[3-i]) return i;
        end
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            body_c++;
        end
    endtask

    task automatic model_press(input logic [3:0] m);
        int c;
        c = pick_idx(m);
        if (c >= 0 && c != (m_way ^ 1)) m_pend = c;
    endtask

    task automatic press(input logic [3:0] m);
        model_press(m);
        btn = m;
        tick(6);
        btn = 4'b0000;
        tick(6);
    endtask

    // Runs from the vld sample point through the body walk, ending with is_end.
    task automatic body_phase(input logic [3:0] m1, input logic [3:0] m2,
                              input int neat, input int extra, input bit glitch);
        body_c = 0;
        if (glitch) begin
            btn = 4'b0001;
            tick(2);
            btn = 4'b0000;
            tick(6);
        end
        if (m1 != 4'b0000) press(m1);
        if (m2 != 4'b0000) press(m2);
        for (int e = 0; e < neat; e++) begin
            u_if.eat = 1'b1;
            tick(1);
            u_if.eat = 1'b0;
            m_grow = 1'b1;
            tick(1);
        end
        tick(extra);
        if (body_c == 0) tick(1);
        last_d = body_c;
        u_if.is_end = 1'b1;
        tick(1);
        u_if.is_end = 1'b0;
    endtask

    task automatic wait_vld(input int budget);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (u_if.vld !== 1'b1 && w < budget);
        #1;
    endtask

    task automatic next_step();
        int t0;
        t0 = t_vld;
        m_way = m_pend;
        if (m_grow) begin
            m_len  = (m_len < 200) ? m_len + 1 : 200;
            m_grow = 1'b0;
        end
        exp_vld_cnt++;
        wait_vld(1 + last_d + TICK_DIV + 20);
        t_vld = cyc;
        chk("period", t_vld - t0, 1 + last_d + TICK_DIV);
        chk("way", u_if.way, oh(m_way));
        chk("length", u_if.length, m_len);
        chk("vld_count", vld_cnt, exp_vld_cnt);
    endtask

    task automatic restart_model();
        m_way = 0; m_pend = 0; m_len = 3; m_grow = 1'b0;
    endtask

    task automatic start_and_first_vld();
        int mr0;
        mr0 = mr_cnt;
        start = 1'b1;
        repeat (8) @(negedge clk);
        start = 1'b0;
        restart_model();
        exp_vld_cnt++;
        wait_vld(40);
        t_vld = cyc;
        chk("move_rst_pulses", mr_cnt - mr0, 1);
        chk("first_vld_delay", t_vld - last_mr_cyc, TICK_DIV);
        chk("first_way", u_if.way, 4'b1000);
        chk("first_length", u_if.length, 3);
        chk("first_vld_count", vld_cnt, exp_vld_cnt);
    endtask

    initial begin
        logic [3:0] r1, r2;
        rst = 1'b0; btn = 4'b0000; start = 1'b0;
        u_if.eat = 1'b0; u_if.is_end = 1'b0; u_if.bite_self = 1'b0;
        restart_model();
        repeat (3) @(negedge clk);
        chk("rst_way", u_if.way, 4'b1000);
        chk("rst_length", u_if.length, 3);
        chk("rst_vld", u_if.vld, 1'b0);
        chk("rst_move_rst", u_if.move_rst, 1'b0);
        chk("rst_game_over", game_over, 1'b0);
        chk("rst_running", running, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // start, first step, steady pacing with is_end 5 cycles after vld
        start_and_first_vld();
        chk("running_on", running, 1'b1);
        for (int i = 0; i < 3; i++) begin
            body_phase(4'b0000, 4'b0000, 0, 5, 1'b0);
            next_step();
        end

        // reversal rejected, later press wins; short glitch ignored
        body_phase(4'b0100, 4'b0010, 0, 0, 1'b0);
        next_step();
        body_phase(4'b0000, 4'b0000, 0, 0, 1'b1);
        next_step();

        // growth: two eats give +1, then nothing, then one more
        body_phase(4'b0000, 4'b0000, 2, 0, 1'b0);
        next_step();
        body_phase(4'b0000, 4'b0000, 0, 3, 1'b0);
        next_step();
        body_phase(4'b0000, 4'b0000, 1, 0, 1'b0);
        next_step();

        // randomized play
        for (int i = 0; i < 40; i++) begin
            r1 = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            r2 = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            body_phase(r1, r2, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
            next_step();
        end

        // saturate at MAX_LEN and one extra eat
        while (m_len < 200 && total < 5000) begin
            body_phase(4'b0000, 4'b0000, 1, 0, 1'b0);
            next_step();
        end
        body_phase(4'b0000, 4'b0000, 1, 0, 1'b0);
        next_step();
        chk("saturated", u_if.length, 200);

        // bite in WAIT ends the game
        body_phase(4'b0000, 4'b0000, 0, 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        u_if.bite_self = 1'b1;
        @(negedge clk);
        #1;
        u_if.bite_self = 1'b0;
        chk("game_over_set", game_over, 1'b1);
        chk("running_off", running, 1'b0);
        repeat (3 * TICK_DIV) @(negedge clk);
        #1;
        chk("no_vld_in_over", vld_cnt, exp_vld_cnt);
        chk("game_over_hold", game_over, 1'b1);

        // restart from OVER
        start_and_first_vld();
        chk("game_over_clear", game_over, 1'b0);
        body_phase(4'b0010, 4'b0000, 1, 0, 1'b0);
        next_step();

        // is_end withheld: BODY times out
        last_d = BODY_TO;
        next_step();

        // asynchronous reset in the middle of BODY
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_way", u_if.way, 4'b1000);
        chk("midrst_length", u_if.length, 3);
        chk("midrst_vld", u_if.vld, 1'b0);
        chk("midrst_move_rst", u_if.move_rst, 1'b0);
        chk("midrst_game_over", game_over, 1'b0);
        chk("midrst_running", running, 1'b0);
        chk("vld_and_move_rst_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
